// File: rtl/bc_buffer_pkg.sv
// rtl/bc_buffer_pkg.sv - shared types and helpers for the ctrl/avoid bidirectional buffer
package bc_buffer_pkg;

    typedef enum logic {
        BC_MODE_BACKPRESSURE = 1'b0,
        BC_MODE_DROP_OLDEST  = 1'b1
    } bc_mode_e;

    localparam int BC_DEFAULT_DEPTH = 16;

    // Occupancy needs one bit more than the pointers so that "full" is representable.
    function automatic int LEVEL_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [LEVEL_W(BC_DEFAULT_DEPTH)-1:0] bc_level_t;

endpackage

// File: rtl/bc_fifo_ch.sv
// rtl/bc_fifo_ch.sv - one first-word-fall-through channel with registered head, flush and optional drop-oldest
module bc_fifo_ch
    import bc_buffer_pkg::*;
#(
    parameter int       DATA_W    = 16,
    parameter int       DEPTH     = 16,
    parameter int       AF_THRESH = DEPTH - 2,
    parameter bc_mode_e MODE      = BC_MODE_BACKPRESSURE,
    parameter int       CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid_i,
    input  logic [DATA_W-1:0]           in_data_i,
    output logic                        in_rdy_o,
    output logic                        out_valid_o,
    output logic [DATA_W-1:0]           out_data_o,
    input  logic                        out_rdy_i,
    input  logic                        flush_i,
    output logic [LEVEL_W(DEPTH)-1:0]   level_o,
    output logic                        almost_full_o,
    output logic [CNT_W-1:0]            drop_cnt_o
);

    localparam int                PW       = $clog2(DEPTH);
    localparam int                LW       = LEVEL_W(DEPTH);
    localparam logic [LW-1:0]     FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0]     AF_LVL   = LW'(AF_THRESH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam bit                DROP_EN  = (MODE == BC_MODE_DROP_OLDEST);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              af_q, af_d;
    logic              in_rdy_q, in_rdy_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic wr_en, rd_en, drop, head_from_in;

    assign wr_en = in_valid_i && in_rdy_q && !flush_i;
    assign rd_en = out_valid_q && out_rdy_i && !flush_i;
    assign drop  = DROP_EN && wr_en && !rd_en && (level_q == FULL_LVL);
    // The write lands in memory at this edge, so a new head that is the incoming word must bypass it.
    assign head_from_in = wr_en && ((level_q == '0) || (rd_en && (level_q == LW'(1))));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        out_data_d = out_data_q;
        drop_cnt_d = drop_cnt_q;

        if (drop && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_en || drop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (wr_en && !rd_en && !drop) begin
                level_d = level_q + LW'(1);
            end else if (rd_en && !wr_en) begin
                level_d = level_q - LW'(1);
            end
            if (head_from_in) begin
                out_data_d = in_data_i;
            end else if (level_d != '0) begin
                out_data_d = mem_q[rd_ptr_d];
            end
        end

        out_valid_d = (level_d != '0);
        af_d        = (level_d >= AF_LVL);
        in_rdy_d    = DROP_EN || (level_d < FULL_LVL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            af_q        <= 1'b0;
            in_rdy_q    <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            af_q        <= af_d;
            in_rdy_q    <= in_rdy_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign in_rdy_o      = in_rdy_q;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign level_o       = level_q;
    assign almost_full_o = af_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: rtl/bc_buffer_gen2.sv
// rtl/bc_buffer_gen2.sv - two independent FIFO channels between the control and avoidance blocks
module bc_buffer_gen2
    import bc_buffer_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int DEPTH           = 16,
    parameter int AF_THRESH       = DEPTH - 2,
    parameter int C2A_DROP_OLDEST = 0,
    parameter int A2C_DROP_OLDEST = 0,
    parameter int CNT_W           = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ctrl_in_valid,
    input  logic [DATA_W-1:0]         ctrl_in_data,
    output logic                      ctrl_in_rdy,
    output logic                      avoid_out_valid,
    output logic [DATA_W-1:0]         avoid_out_data,
    input  logic                      avoid_out_rdy,
    input  logic                      avoid_in_valid,
    input  logic [DATA_W-1:0]         avoid_in_data,
    output logic                      avoid_in_rdy,
    output logic                      ctrl_out_valid,
    output logic [DATA_W-1:0]         ctrl_out_data,
    input  logic                      ctrl_out_rdy,
    input  logic                      c2a_flush,
    input  logic                      a2c_flush,
    output logic [LEVEL_W(DEPTH)-1:0] c2a_level,
    output logic [LEVEL_W(DEPTH)-1:0] a2c_level,
    output logic                      c2a_almost_full,
    output logic                      a2c_almost_full,
    output logic [CNT_W-1:0]          c2a_drop_cnt,
    output logic [CNT_W-1:0]          a2c_drop_cnt
);

    localparam bc_mode_e C2A_MODE = (C2A_DROP_OLDEST != 0) ? BC_MODE_DROP_OLDEST : BC_MODE_BACKPRESSURE;
    localparam bc_mode_e A2C_MODE = (A2C_DROP_OLDEST != 0) ? BC_MODE_DROP_OLDEST : BC_MODE_BACKPRESSURE;

    bc_fifo_ch #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .MODE      (C2A_MODE),
        .CNT_W     (CNT_W)
    ) u_c2a (
        .clk           (clk),
        .rst_n         (rst),
        .in_valid_i    (ctrl_in_valid),
        .in_data_i     (ctrl_in_data),
        .in_rdy_o      (ctrl_in_rdy),
        .out_valid_o   (avoid_out_valid),
        .out_data_o    (avoid_out_data),
        .out_rdy_i     (avoid_out_rdy),
        .flush_i       (c2a_flush),
        .level_o       (c2a_level),
        .almost_full_o (c2a_almost_full),
        .drop_cnt_o    (c2a_drop_cnt)
    );

    bc_fifo_ch #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .MODE      (A2C_MODE),
        .CNT_W     (CNT_W)
    ) u_a2c (
        .clk           (clk),
        .rst_n         (rst),
        .in_valid_i    (avoid_in_valid),
        .in_data_i     (avoid_in_data),
        .in_rdy_o      (avoid_in_rdy),
        .out_valid_o   (ctrl_out_valid),
        .out_data_o    (ctrl_out_data),
        .out_rdy_i     (ctrl_out_rdy),
        .flush_i       (a2c_flush),
        .level_o       (a2c_level),
        .almost_full_o (a2c_almost_full),
        .drop_cnt_o    (a2c_drop_cnt)
    );

endmodule

// File: tb/tb_bc_buffer_gen2.sv
// tb/tb_bc_buffer_gen2.sv - directed table-driven bench for bc_buffer_gen2
module tb_bc_buffer_gen2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ctrl_in_valid, avoid_out_rdy, avoid_in_valid, ctrl_out_rdy, c2a_flush, a2c_flush;
    logic [15:0] ctrl_in_data, avoid_in_data;
    logic        ctrl_in_rdy, avoid_out_valid, avoid_in_rdy, ctrl_out_valid, c2a_af, a2c_af;
    logic [15:0] avoid_out_data, ctrl_out_data, c2a_drop_cnt, a2c_drop_cnt;
    logic [4:0]  c2a_level, a2c_level;

    bc_buffer_gen2 u_dut (
        .clk(clk), .rst(rst),
        .ctrl_in_valid(ctrl_in_valid), .ctrl_in_data(ctrl_in_data), .ctrl_in_rdy(ctrl_in_rdy),
        .avoid_out_valid(avoid_out_valid), .avoid_out_data(avoid_out_data), .avoid_out_rdy(avoid_out_rdy),
        .avoid_in_valid(avoid_in_valid), .avoid_in_data(avoid_in_data), .avoid_in_rdy(avoid_in_rdy),
        .ctrl_out_valid(ctrl_out_valid), .ctrl_out_data(ctrl_out_data), .ctrl_out_rdy(ctrl_out_rdy),
        .c2a_flush(c2a_flush), .a2c_flush(a2c_flush),
        .c2a_level(c2a_level), .a2c_level(a2c_level),
        .c2a_almost_full(c2a_af), .a2c_almost_full(a2c_af),
        .c2a_drop_cnt(c2a_drop_cnt), .a2c_drop_cnt(a2c_drop_cnt)
    );

    // Second instance: DEPTH=4, a2c in drop-oldest mode, 2-bit drop counter to reach saturation quickly.
    logic        d_avoid_in_valid, d_ctrl_out_rdy;
    logic [15:0] d_avoid_in_data;
    logic        d_ctrl_in_rdy, d_avoid_out_valid, d_avoid_in_rdy, d_ctrl_out_valid, d_c2a_af, d_a2c_af;
    logic [15:0] d_avoid_out_data, d_ctrl_out_data;
    logic [1:0]  d_c2a_drop_cnt, d_a2c_drop_cnt;
    logic [2:0]  d_c2a_level, d_a2c_level;

    bc_buffer_gen2 #(.DATA_W(16), .DEPTH(4), .A2C_DROP_OLDEST(1), .CNT_W(2)) u_drp (
        .clk(clk), .rst(rst),
        .ctrl_in_valid(1'b0), .ctrl_in_data(16'h0000), .ctrl_in_rdy(d_ctrl_in_rdy),
        .avoid_out_valid(d_avoid_out_valid), .avoid_out_data(d_avoid_out_data), .avoid_out_rdy(1'b0),
        .avoid_in_valid(d_avoid_in_valid), .avoid_in_data(d_avoid_in_data), .avoid_in_rdy(d_avoid_in_rdy),
        .ctrl_out_valid(d_ctrl_out_valid), .ctrl_out_data(d_ctrl_out_data), .ctrl_out_rdy(d_ctrl_out_rdy),
        .c2a_flush(1'b0), .a2c_flush(1'b0),
        .c2a_level(d_c2a_level), .a2c_level(d_a2c_level),
        .c2a_almost_full(d_c2a_af), .a2c_almost_full(d_a2c_af),
        .c2a_drop_cnt(d_c2a_drop_cnt), .a2c_drop_cnt(d_a2c_drop_cnt)
    );

    typedef struct {
        logic        ch;
        logic        v;
        logic [15:0] d;
        logic        rdy;
        logic        fl;
        logic [4:0]  e_lvl;
        logic        e_val;
        logic [15:0] e_dat;
        logic        e_irdy;
        logic        e_af;
    } vec_t;

    vec_t tab[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic ch, logic v, logic [15:0] d, logic rdy, logic fl,
                                logic [4:0] lvl, logic val, logic [15:0] dat, logic irdy, logic af);
        vec_t r;
        r.ch = ch; r.v = v; r.d = d; r.rdy = rdy; r.fl = fl;
        r.e_lvl = lvl; r.e_val = val; r.e_dat = dat; r.e_irdy = irdy; r.e_af = af;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_main();
        ctrl_in_valid = 1'b0; avoid_out_rdy = 1'b0; c2a_flush = 1'b0;
        avoid_in_valid = 1'b0; ctrl_out_rdy = 1'b0; a2c_flush = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        idle_main();
        if (v.ch == 1'b0) begin
            ctrl_in_valid = v.v; ctrl_in_data = v.d; avoid_out_rdy = v.rdy; c2a_flush = v.fl;
        end else begin
            avoid_in_valid = v.v; avoid_in_data = v.d; ctrl_out_rdy = v.rdy; a2c_flush = v.fl;
        end
        step();
        if (v.ch == 1'b0) begin
            chk($sformatf("vec%0d_c2a_level", idx), 32'(c2a_level), 32'(v.e_lvl));
            chk($sformatf("vec%0d_c2a_valid", idx), 32'(avoid_out_valid), 32'(v.e_val));
            chk($sformatf("vec%0d_c2a_in_rdy", idx), 32'(ctrl_in_rdy), 32'(v.e_irdy));
            chk($sformatf("vec%0d_c2a_af", idx), 32'(c2a_af), 32'(v.e_af));
            if (v.e_val) chk($sformatf("vec%0d_c2a_data", idx), 32'(avoid_out_data), 32'(v.e_dat));
        end else begin
            chk($sformatf("vec%0d_a2c_level", idx), 32'(a2c_level), 32'(v.e_lvl));
            chk($sformatf("vec%0d_a2c_valid", idx), 32'(ctrl_out_valid), 32'(v.e_val));
            chk($sformatf("vec%0d_a2c_in_rdy", idx), 32'(avoid_in_rdy), 32'(v.e_irdy));
            chk($sformatf("vec%0d_a2c_af", idx), 32'(a2c_af), 32'(v.e_af));
            if (v.e_val) chk($sformatf("vec%0d_a2c_data", idx), 32'(ctrl_out_data), 32'(v.e_dat));
        end
    endtask

    task automatic chk_drp(input string nm, input int lvl, input int cnt, input logic val, input int dat);
        chk({nm, "_level"}, 32'(d_a2c_level), 32'(lvl));
        chk({nm, "_drop"}, 32'(d_a2c_drop_cnt), 32'(cnt));
        chk({nm, "_valid"}, 32'(d_ctrl_out_valid), 32'(val));
        chk({nm, "_in_rdy"}, 32'(d_avoid_in_rdy), 32'd1);
        if (val) chk({nm, "_data"}, 32'(d_ctrl_out_data), 32'(dat));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_c2a_level"}, 32'(c2a_level), 32'd0);
        chk({nm, "_a2c_level"}, 32'(a2c_level), 32'd0);
        chk({nm, "_c2a_valid"}, 32'(avoid_out_valid), 32'd0);
        chk({nm, "_a2c_valid"}, 32'(ctrl_out_valid), 32'd0);
        chk({nm, "_c2a_data"}, 32'(avoid_out_data), 32'd0);
        chk({nm, "_a2c_data"}, 32'(ctrl_out_data), 32'd0);
        chk({nm, "_c2a_in_rdy"}, 32'(ctrl_in_rdy), 32'd0);
        chk({nm, "_a2c_in_rdy"}, 32'(avoid_in_rdy), 32'd0);
        chk({nm, "_c2a_af"}, 32'(c2a_af), 32'd0);
        chk({nm, "_a2c_af"}, 32'(a2c_af), 32'd0);
        chk({nm, "_c2a_drop"}, 32'(c2a_drop_cnt), 32'd0);
        chk({nm, "_drp_level"}, 32'(d_a2c_level), 32'd0);
        chk({nm, "_drp_drop"}, 32'(d_a2c_drop_cnt), 32'd0);
        chk({nm, "_drp_in_rdy"}, 32'(d_avoid_in_rdy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // c2a: ten writes, then ten pops
        for (int i = 0; i < 10; i++)
            tab.push_back(mk(1'b0, 1'b1, 16'(10 + i), 1'b0, 1'b0, 5'(i + 1), 1'b1, 16'h000A, 1'b1, 1'b0));
        for (int j = 0; j < 10; j++)
            tab.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5'(9 - j), (j < 9), 16'(11 + j), 1'b1, 1'b0));
        // a2c: fill to 16, then drain with a blocked write on the first pop
        for (int k = 0; k < 16; k++)
            tab.push_back(mk(1'b1, 1'b1, 16'(256 + k), 1'b0, 1'b0, 5'(k + 1), 1'b1, 16'h0100,
                             ((k + 1) < 16), ((k + 1) >= 14)));
        for (int p = 1; p <= 16; p++)
            tab.push_back(mk(1'b1, (p == 1), 16'h0BAD, 1'b1, 1'b0, 5'(16 - p), (p < 16), 16'(256 + p),
                             1'b1, ((16 - p) >= 14)));

        idle_main();
        ctrl_in_data = '0; avoid_in_data = '0;
        d_avoid_in_valid = 1'b0; d_avoid_in_data = '0; d_ctrl_out_rdy = 1'b0;
        rst = 1'b0;
        #2;
        chk_reset_vals("rst0");
        step();
        chk("rst_held_in_rdy", 32'(ctrl_in_rdy), 32'd0);
        rst = 1'b1;
        step();
        chk("rel_c2a_in_rdy", 32'(ctrl_in_rdy), 32'd1);
        chk("rel_a2c_in_rdy", 32'(avoid_in_rdy), 32'd1);
        chk("rel_drp_in_rdy", 32'(d_avoid_in_rdy), 32'd1);

        foreach (tab[i]) run_vec(tab[i], i);

        // Streaming: one write and one pop every cycle
        idle_main();
        ctrl_in_valid = 1'b1; avoid_out_rdy = 1'b1; ctrl_in_data = 16'h1000;
        step();
        chk("stream_first_level", 32'(c2a_level), 32'd1);
        chk("stream_first_data", 32'(avoid_out_data), 32'h1000);
        for (int k = 1; k <= 100; k++) begin
            ctrl_in_data = 16'(16'h1000 + k);
            step();
            chk($sformatf("stream%0d_level", k), 32'(c2a_level), 32'd1);
            chk($sformatf("stream%0d_valid", k), 32'(avoid_out_valid), 32'd1);
            chk($sformatf("stream%0d_data", k), 32'(avoid_out_data), 32'(16'h1000 + k));
        end
        ctrl_in_valid = 1'b0;
        step();
        chk("stream_end_level", 32'(c2a_level), 32'd0);
        chk("stream_end_valid", 32'(avoid_out_valid), 32'd0);
        avoid_out_rdy = 1'b0;

        // Drop-oldest on the DEPTH=4 instance
        d_avoid_in_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            d_avoid_in_data = 16'(i);
            step();
            chk_drp($sformatf("drop_wr%0d", i), (i < 4) ? i : 4, (i > 4) ? i - 4 : 0, 1'b1, (i <= 4) ? 1 : i - 3);
        end
        d_avoid_in_valid = 1'b0; d_ctrl_out_rdy = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            step();
            chk_drp($sformatf("drop_pop%0d", p), 4 - p, 2, (p < 4), 3 + p);
        end
        d_ctrl_out_rdy = 1'b0; d_avoid_in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d_avoid_in_data = 16'(16'h10 + i);
            step();
            chk_drp($sformatf("drop_refill%0d", i), i, 2, 1'b1, 16'h11);
        end
        d_avoid_in_data = 16'h15; d_ctrl_out_rdy = 1'b1;
        step();
        chk_drp("drop_full_pushpop", 4, 2, 1'b1, 16'h12);
        d_ctrl_out_rdy = 1'b0; d_avoid_in_data = 16'h16;
        step();
        chk_drp("drop_to_max", 4, 3, 1'b1, 16'h13);
        d_avoid_in_data = 16'h17;
        step();
        chk_drp("drop_saturate", 4, 3, 1'b1, 16'h14);
        d_avoid_in_valid = 1'b0;

        // Flush with a simultaneous write and pop
        for (int i = 0; i < 5; i++) begin
            ctrl_in_valid = 1'b1; ctrl_in_data = 16'(16'h50 + i);
            avoid_in_valid = (i < 2); avoid_in_data = 16'(16'h200 + i);
            step();
        end
        idle_main();
        chk("flush_pre_c2a_level", 32'(c2a_level), 32'd5);
        chk("flush_pre_a2c_level", 32'(a2c_level), 32'd2);
        c2a_flush = 1'b1; ctrl_in_valid = 1'b1; ctrl_in_data = 16'h00EE; avoid_out_rdy = 1'b1;
        step();
        chk("flush_c2a_level", 32'(c2a_level), 32'd0);
        chk("flush_c2a_valid", 32'(avoid_out_valid), 32'd0);
        chk("flush_c2a_in_rdy", 32'(ctrl_in_rdy), 32'd1);
        chk("flush_a2c_level", 32'(a2c_level), 32'd2);
        chk("flush_a2c_valid", 32'(ctrl_out_valid), 32'd1);
        chk("flush_a2c_data", 32'(ctrl_out_data), 32'h200);
        c2a_flush = 1'b0; avoid_out_rdy = 1'b0; ctrl_in_data = 16'h0077;
        step();
        chk("post_flush_level", 32'(c2a_level), 32'd1);
        chk("post_flush_valid", 32'(avoid_out_valid), 32'd1);
        chk("post_flush_data", 32'(avoid_out_data), 32'h0077);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++) begin
            ctrl_in_data = 16'(16'h80 + i);
            step();
        end
        chk("burst_level", 32'(c2a_level), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("arst");
        idle_main();
        #2;
        rst = 1'b1;
        step();
        chk("arst_rel_in_rdy", 32'(ctrl_in_rdy), 32'd1);
        chk("arst_rel_level", 32'(c2a_level), 32'd0);
        ctrl_in_valid = 1'b1; ctrl_in_data = 16'h0099;
        step();
        ctrl_in_valid = 1'b0;
        chk("arst_wr_level", 32'(c2a_level), 32'd1);
        chk("arst_wr_valid", 32'(avoid_out_valid), 32'd1);
        chk("arst_wr_data", 32'(avoid_out_data), 32'h0099);
        step();
        chk("arst_hold_data", 32'(avoid_out_data), 32'h0099);
        chk("arst_hold_level", 32'(c2a_level), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
